// File: rtl/fp_enco.sv
// fp_enco: normalizes a 48-bit mantissa product one shift per cycle, rounds it and packs an IEEE-754 single.
// Defining FP_ENCO_ROUND_EN selects round-to-nearest-even; without it the significand is truncated.
module fp_enco (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        signo,
  input  logic [9:0]  exponente,
  input  logic [47:0] mantissa,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] float_num,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]         state_r;
  logic               sign_r;
  logic signed [10:0] exp_r;
  logic [47:0]        mant_r;
  logic               sticky_r;
  logic               outValid_r;
  logic [31:0]        floatNum_r;
  logic               overflow_r;
  logic               underflow_r;
  logic               inexact_r;

  logic [23:0]        rndMant_s;
  logic               guard_s;
  logic               sticky_s;
  logic               roundUp_s;
  logic [24:0]        mantSum_s;
  logic [23:0]        finMant_s;
  logic signed [10:0] finExp_s;
  logic [31:0]        packed_s;
  logic               ovf_s;
  logic               unf_s;
  logic               inx_s;

  // Rounding and packing of the normalized significand (bit 46 is the hidden one).
  always_comb begin
    rndMant_s = mant_r[46:23];
    guard_s   = mant_r[22];
    sticky_s  = sticky_r | (|mant_r[21:0]);
`ifdef FP_ENCO_ROUND_EN
    roundUp_s = guard_s & (sticky_s | rndMant_s[0]);
`else
    roundUp_s = 1'b0;
`endif
    mantSum_s = {1'b0, rndMant_s} + {24'd0, roundUp_s};
    if (mantSum_s[24]) begin
      finMant_s = 24'h80_0000;
      finExp_s  = exp_r + 11'sd1;
    end else begin
      finMant_s = mantSum_s[23:0];
      finExp_s  = exp_r;
    end
    inx_s = guard_s | sticky_s;
    ovf_s = 1'b0;
    unf_s = 1'b0;
    if (finExp_s >= 11'sd255) begin
      packed_s = {sign_r, 8'hFF, 23'h0};
      ovf_s    = 1'b1;
      inx_s    = 1'b1;
    end else if (finExp_s <= 11'sd0) begin
      packed_s = {sign_r, 31'h0};
      unf_s    = 1'b1;
      inx_s    = 1'b1;
    end else begin
      packed_s = {sign_r, finExp_s[7:0], finMant_s[22:0]};
    end
  end

  // Operand capture, iterative normalization and result holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sign_r      <= 1'b0;
      exp_r       <= 11'sd0;
      mant_r      <= 48'h0;
      sticky_r    <= 1'b0;
      outValid_r  <= 1'b0;
      floatNum_r  <= 32'h0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      inexact_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sign_r   <= signo;
            exp_r    <= {exponente[9], exponente};
            mant_r   <= mantissa;
            sticky_r <= 1'b0;
            state_r  <= NORM;
          end
        end
        NORM: begin
          if (mant_r == 48'h0) begin
            floatNum_r  <= {sign_r, 31'h0};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            inexact_r   <= 1'b0;
            outValid_r  <= 1'b1;
            state_r     <= OUT;
          end else if (mant_r[47]) begin
            mant_r   <= {1'b0, mant_r[47:1]};
            exp_r    <= exp_r + 11'sd1;
            sticky_r <= sticky_r | mant_r[0];
          end else if (mant_r[46]) begin
            state_r <= ROUND;
          end else begin
            mant_r <= {mant_r[46:0], 1'b0};
            exp_r  <= exp_r - 11'sd1;
          end
        end
        ROUND: begin
          floatNum_r  <= packed_s;
          overflow_r  <= ovf_s;
          underflow_r <= unf_s;
          inexact_r   <= inx_s;
          outValid_r  <= 1'b1;
          state_r     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            outValid_r <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          outValid_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = outValid_r;
  assign float_num = floatNum_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign inexact   = inexact_r;

endmodule

// File: tb/tb_fp_enco.sv
// Directed self-checking bench for fp_enco; the expected result comes from a leading-one
// normalization model and each vector also carries a hand-computed literal.
module tb_fp_enco;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        signo = 1'b0;
  logic [9:0]  exponente = 10'd0;
  logic [47:0] mantissa = 48'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] float_num;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  int total = 0;
  int bad = 0;

  logic [31:0] mFloat = 32'h0;
  logic [2:0]  mFlags = 3'b000;
  int          mLat = 0;
  logic        armed = 1'b0;

  fp_enco dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .signo(signo), .exponente(exponente), .mantissa(mantissa),
    .out_valid(out_valid), .out_ready(out_ready), .float_num(float_num),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: locate the leading one, align it to the top of a wide word, then round and pack.
  task automatic model(input logic s, input logic [9:0] e, input logic [47:0] m,
                       output logic [31:0] f, output logic [2:0] fl, output int lat);
    int p;
    int ev;
    logic [95:0] w;
    logic [23:0] sig;
    logic [24:0] sum;
    logic g;
    logic st;
    if (m == 48'h0) begin
      f = {s, 31'h0};
      fl = 3'b000;
      lat = 1;
    end else begin
      p = 0;
      for (int i = 0; i < 48; i++) if (m[i]) p = i;
      w = {m, 48'h0} << (47 - p);
      sig = w[95:72];
      g = w[71];
      st = |w[70:0];
      ev = int'($signed(e)) + p - 46;
      lat = ((p >= 46) ? (p - 46) : (46 - p)) + 2;
`ifdef FP_ENCO_ROUND_EN
      if (g && (st || sig[0])) begin
        sum = {1'b0, sig} + 25'd1;
        if (sum[24]) begin
          sig = 24'h80_0000;
          ev = ev + 1;
        end else begin
          sig = sum[23:0];
        end
      end
`else
      sum = 25'd0;
`endif
      if (ev >= 255) begin
        f = {s, 8'hFF, 23'h0};
        fl = 3'b101;
      end else if (ev <= 0) begin
        f = {s, 31'h0};
        fl = 3'b011;
      end else begin
        f = {s, ev[7:0], sig[22:0]};
        fl = {2'b00, g | st};
      end
    end
  endtask

  // Continuous check of the presented result while it is valid.
  always @(negedge clk) begin
    if (rst_n && armed && out_valid) begin
      chk("float_num", {32'h0, float_num}, {32'h0, mFloat});
      chk("flags", {61'h0, overflow, underflow, inexact}, {61'h0, mFlags});
      chk("in_ready_busy", {63'h0, in_ready}, 64'h0);
    end
  end

  task automatic run(input string name, input logic s, input logic [9:0] e, input logic [47:0] m,
                     input int hold, input logic [31:0] litF, input logic [2:0] litFl, input int litLat);
    int lat;
    int waitc;
    logic [31:0] f;
    logic [2:0] fl;
    model(s, e, m, f, fl, lat);
    chk({name, "_model_f"}, {32'h0, f}, {32'h0, litF});
    chk({name, "_model_fl"}, {61'h0, fl}, {61'h0, litFl});
    chk({name, "_model_lat"}, 64'(lat), 64'(litLat));
    mFloat = litF;
    mFlags = litFl;
    mLat = litLat;
    armed = 1'b1;
    @(negedge clk);
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    chk({name, "_in_ready"}, {63'h0, in_ready}, 64'h1);
    signo = s;
    exponente = e;
    mantissa = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mantissa = 48'hDEAD_BEEF_0000;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(mLat));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      signo = ~s;
      mantissa = 48'h4000_0000_0000;
      chk({name, "_hold_valid"}, {63'h0, out_valid}, 64'h1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk({name, "_drop_valid"}, {63'h0, out_valid}, 64'h0);
    chk({name, "_ready_back"}, {63'h0, in_ready}, 64'h1);
    chk({name, "_held_f"}, {32'h0, float_num}, {32'h0, litF});
    armed = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_float", {32'h0, float_num}, 64'h0);
    chk("rst_flags", {61'h0, overflow, underflow, inexact}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run("one",      1'b0, 10'd127, 48'h4000_0000_0000, 0, 32'h3F80_0000, 3'b000, 2);
    run("two_neg",  1'b1, 10'd127, 48'h8000_0000_0000, 0, 32'hC000_0000, 3'b000, 3);
    run("tiny",     1'b0, 10'd173, 48'h0000_0000_0001, 0, 32'h3F80_0000, 3'b000, 48);
    run("onehalf",  1'b0, 10'd127, 48'h6000_0000_0000, 0, 32'h3FC0_0000, 3'b000, 2);
    run("shsticky", 1'b0, 10'd127, 48'h8000_0100_0001, 0, 32'h4000_0001, 3'b001, 3);
    run("tie_even", 1'b0, 10'd127, 48'h4000_0040_0000, 0, 32'h3F80_0000, 3'b001, 2);
`ifdef FP_ENCO_ROUND_EN
    run("tie_odd",  1'b0, 10'd127, 48'h7FFF_FFC0_0000, 0, 32'h4000_0000, 3'b001, 2);
    run("above",    1'b0, 10'd127, 48'h4000_0060_0000, 0, 32'h3F80_0001, 3'b001, 2);
    run("rnd_ovf",  1'b0, 10'd254, 48'h7FFF_FFC0_0000, 0, 32'h7F80_0000, 3'b101, 2);
`else
    run("tie_odd",  1'b0, 10'd127, 48'h7FFF_FFC0_0000, 0, 32'h3FFF_FFFF, 3'b001, 2);
    run("above",    1'b0, 10'd127, 48'h4000_0060_0000, 0, 32'h3F80_0000, 3'b001, 2);
    run("rnd_ovf",  1'b0, 10'd254, 48'h7FFF_FFC0_0000, 0, 32'h7F7F_FFFF, 3'b001, 2);
`endif
    run("ovf300",   1'b0, 10'd300, 48'h4000_0000_0000, 0, 32'h7F80_0000, 3'b101, 2);
    run("maxexp",   1'b0, 10'd254, 48'h4000_0000_0000, 0, 32'h7F00_0000, 3'b000, 2);
    run("ovf255",   1'b0, 10'd255, 48'h4000_0000_0000, 0, 32'h7F80_0000, 3'b101, 2);
    run("unf0",     1'b1, 10'd0,   48'h4000_0000_0000, 0, 32'h8000_0000, 3'b011, 2);
    run("unf_sh",   1'b0, 10'd1,   48'h2000_0000_0000, 0, 32'h0000_0000, 3'b011, 3);
    run("zero",     1'b1, 10'd55,  48'h0,              0, 32'h8000_0000, 3'b000, 1);
    run("bp",       1'b0, 10'd128, 48'h4000_0000_0000, 5, 32'h4000_0000, 3'b000, 2);

    @(negedge clk);
    signo = 1'b0;
    exponente = 10'd173;
    mantissa = 48'h1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'h0, out_valid}, 64'h0);
    chk("mid_rst_float", {32'h0, float_num}, 64'h0);
    chk("mid_rst_ready", {63'h0, in_ready}, 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_rst", 1'b1, 10'd127, 48'h4000_0000_0000, 0, 32'hBF80_0000, 3'b000, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
